ps2_rx_fifo_wb: RTL and testbench

Next-generation PS/2 keyboard port. Integrated frame receiver with parity and framing checks, a parametrised receive FIFO, and a registered Wishbone-style slave exposing data, status, history and control registers. Replaces the single-byte ready/rdn handshake: the CPU pops scancodes one per bus read, and error and overflow conditions are now reported.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_frame_rx.sv | 108 ++++++++++
 rtl/ps2_rx_fifo_wb.sv | 160 ++++++++++++++++
 tb/tb_ps2_rx_fifo_wb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive FIFO with Wishbone slave:
// register offsets, CTRL bit positions, empty-read code and receiver states.
package ps2_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_HIST = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_FLUSH  = 0;
  localparam int unsigned CTRL_CLR    = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam logic [7:0] EMPTY_CODE = 8'hAA;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchroniser, falling-edge detect, frame FSM
// with odd-parity/stop checks and an inter-edge watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] TIMEOUT     = 16'd20000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       par_err_o,
  output logic       frame_err_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [15:0]            wd_q, wd_d;
  logic                   clk_s, data_s, fall;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    wd_d        = '0;
    valid_o     = 1'b0;
    par_err_o   = 1'b0;
    frame_err_o = 1'b0;

    if (!fall && state_q != RX_IDLE) wd_d = wd_q + 16'd1;

    if (!fall && state_q != RX_IDLE && wd_q == TIMEOUT) begin
      state_d     = RX_IDLE;
      frame_err_o = 1'b1;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!data_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_o = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = data_s;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (!data_s)                 frame_err_o = 1'b1;
          else if (^{shift_q, par_q})  valid_o     = 1'b1;
          else                         par_err_o   = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/ps2_rx_fifo_wb.sv
// PS/2 keyboard port: frame receiver, receive FIFO and registered Wishbone slave.
// Define PS2_IRQ_EN to add the registered irq output.
module ps2_rx_fifo_wb
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned HIST_BYTES  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] TIMEOUT     = 16'd20000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PS2_clk,
  input  logic                    PS2_Data,
  input  logic [31:0]             dat_i,
  input  logic [31:0]             adr_i,
  input  logic                    we_i,
  input  logic                    stb_i,
  output logic [31:0]             dat_o,
  output logic                    ack_o,
`ifdef PS2_IRQ_EN
  output logic                    irq,
`endif
  output logic                    ps2_ready,
  output logic [7:0]              key,
  output logic [8*HIST_BYTES-1:0] key_d
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned HW    = 8 * HIST_BYTES;

  logic [7:0]         rx_byte;
  logic               rx_valid, rx_perr, rx_ferr;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic               irq_en_q, irq_en_d, ack_q;
  logic [31:0]        dat_q, dat_d;
  logic [HW-1:0]      key_d_q, key_d_d;
  logic [HW+7:0]      hist_shift;
  logic [7:0]         head, cnt8;
  logic               empty, full, txn, rd, wr, pop, flush, clr, push_ok;
  logic               unused_ok;

  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk_i      (clk),
    .rst_i      (rst),
    .ps2_clk_i  (PS2_clk),
    .ps2_data_i (PS2_Data),
    .byte_o     (rx_byte),
    .valid_o    (rx_valid),
    .par_err_o  (rx_perr),
    .frame_err_o(rx_ferr)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign txn   = stb_i & ~ack_q;
  assign rd    = txn & ~we_i;
  assign wr    = txn & we_i;
  assign pop   = rd & (adr_i[3:2] == REG_DATA) & ~empty;
  assign flush = wr & (adr_i[3:2] == REG_CTRL) & dat_i[CTRL_FLUSH];
  assign clr   = wr & (adr_i[3:2] == REG_CTRL) & dat_i[CTRL_CLR];
  // A pop frees the slot a same-cycle push into a full FIFO needs.
  assign push_ok    = rx_valid & ~flush & (~full | pop);
  assign hist_shift = {key_d_q, head};
  assign cnt8       = 8'(count_q);
  assign unused_ok  = ^{adr_i[31:4], adr_i[1:0], dat_i[31:3]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    key_d_d  = key_d_q;
    irq_en_d = irq_en_q;
    dat_d    = dat_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    if (pop) key_d_d = hist_shift[HW-1:0];

    ovf_d  = clr ? 1'b0 : (ovf_q | (rx_valid & ~flush & full & ~pop));
    perr_d = clr ? 1'b0 : (perr_q | rx_perr);
    ferr_d = clr ? 1'b0 : (ferr_q | rx_ferr);

    if (wr && adr_i[3:2] == REG_CTRL) irq_en_d = dat_i[CTRL_IRQ_EN];

    if (rd) begin
      case (adr_i[3:2])
        REG_DATA: dat_d = empty ? {24'h0, EMPTY_CODE} : {23'h0, 1'b1, head};
        REG_STAT: dat_d = {8'h0, cnt8, 12'h0, irq_en_q, ferr_q, perr_q, ovf_q};
        REG_HIST: dat_d = 32'(key_d_q);
        default:  dat_d = {29'h0, irq_en_q, 2'b00};
      endcase
    end else if (wr) begin
      dat_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      key_d_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      irq_en_q <= irq_en_d;
      ack_q    <= stb_i & ~ack_q;
      dat_q    <= dat_d;
      key_d_q  <= key_d_d;
    end
  end

`ifdef PS2_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_en_q & (~empty | ovf_q | perr_q | ferr_q);
  end
  assign irq = irq_q;
`endif

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign ps2_ready = ~empty;
  assign key       = empty ? EMPTY_CODE : head;
  assign key_d     = key_d_q;

endmodule

// File: tb/tb_ps2_rx_fifo_wb.sv
// Directed + randomized bench for ps2_rx_fifo_wb against a queue-based model.
module tb_ps2_rx_fifo_wb;

  localparam int TO = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PS2_clk = 1'b1;
  logic        PS2_Data = 1'b1;
  logic [31:0] dat_i = '0;
  logic [31:0] adr_i = '0;
  logic        we_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        ps2_ready;
  logic [7:0]  key;
  logic [31:0] key_d;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic [31:0] m_hist = '0;
  logic        m_ovf = 0, m_perr = 0, m_ferr = 0, m_irq_en = 0;

  ps2_rx_fifo_wb dut (
    .clk(clk), .rst(rst), .PS2_clk(PS2_clk), .PS2_Data(PS2_Data),
    .dat_i(dat_i), .adr_i(adr_i), .we_i(we_i), .stb_i(stb_i),
    .dat_o(dat_o), .ack_o(ack_o), .ps2_ready(ps2_ready), .key(key), .key_d(key_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_Data = b;
    cyc(4);
    PS2_clk = 1'b0;
    cyc(4);
    PS2_clk = 1'b1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_hist = '0; m_ovf = 0; m_perr = 0; m_ferr = 0; m_irq_en = 0;
  endtask

  // Full frame; the model applies the receive rules directly.
  task automatic ps2_send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    PS2_Data = 1'b1;
    cyc(8);
    if (bad_stop)      m_ferr = 1;
    else if (bad_par)  m_perr = 1;
    else if (mq.size() == 16) m_ovf = 1;
    else mq.push_back(b);
  endtask

  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] rdat);
    logic got;
    got = 0;
    rdat = 'x;
    @(negedge clk);
    stb_i = 1; we_i = w; adr_i = {28'h0, a, 2'b00}; dat_i = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin got = 1; rdat = dat_o; end
    end
    stb_i = 0; we_i = 0;
    if (!got) chk("ack_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack_o), 32'd0);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] r, e;
    e = (mq.size() != 0) ? {23'h0, 1'b1, mq[0]} : 32'h0000_00AA;
    wb_xfer(0, 2'd0, 32'h0, r);
    chk(tag, r, e);
    if (mq.size() != 0) begin
      m_hist = {m_hist[23:0], mq[0]};
      void'(mq.pop_front());
    end
    chk({tag, "_key_d"}, key_d, m_hist);
  endtask

  task automatic rd_stat(input string tag);
    logic [31:0] r;
    wb_xfer(0, 2'd1, 32'h0, r);
    chk(tag, r, {8'h0, 8'(mq.size()), 12'h0, m_irq_en, m_ferr, m_perr, m_ovf});
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1, 2'd3, d, r);
    if (d[0]) mq.delete();
    if (d[1]) begin m_ovf = 0; m_perr = 0; m_ferr = 0; end
    m_irq_en = d[2];
  endtask

  task automatic chk_head(input string tag);
    chk({tag, "_ready"}, 32'(ps2_ready), 32'(mq.size() != 0));
    chk({tag, "_key"}, 32'(key), (mq.size() != 0) ? 32'(mq[0]) : 32'hAA);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0] b;

    // Reset state
    cyc(3);
    @(negedge clk); rst = 0;
    #1;
    chk("rst_ready", 32'(ps2_ready), 32'd0);
    chk("rst_key", 32'(key), 32'hAA);
    chk("rst_key_d", key_d, 32'h0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    cyc(4);

    // Single frame 0x1C then pop
    ps2_send(8'h1C, 0, 0);
    chk_head("f1c");
    rd_data("rd_1c");
    chk_head("after_1c");
    chk("key_d_1c", key_d, 32'h0000_001C);

    // Empty read
    rd_data("rd_empty");
    rd_stat("stat_empty");

    // Overflow: 17 frames
    for (int i = 0; i < 17; i++) ps2_send(8'($urandom), 0, 0);
    rd_stat("stat_full");
    chk_head("full");
    for (int i = 0; i < 16; i++) rd_data("drain");
    rd_stat("stat_drained");
    wr_ctrl(32'h2);
    rd_stat("stat_ovf_clr");

    // Parity and stop errors
    ps2_send(8'h5A, 1, 0);
    rd_stat("stat_par");
    ps2_send(8'($urandom), 0, 1);
    rd_stat("stat_frame");
    wr_ctrl(32'h2);
    rd_stat("stat_err_clr");

    // Watchdog abort of a partial frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
    PS2_Data = 1'b1;
    cyc(TO + 10);
    m_ferr = 1;
    ps2_send(8'hF0, 0, 0);
    rd_stat("stat_timeout");
    rd_data("rd_f0");
    rd_data("rd_after_f0");

    // Randomized interleaving of frames and pops
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) ps2_send(8'($urandom), 0, 0);
      else rd_data("rand_rd");
      chk_head("rand");
    end
    wb_xfer(0, 2'd2, 32'h0, r);
    chk("hist", r, m_hist);

    // Flush and irq_en
    for (int i = 0; i < 3; i++) ps2_send(8'($urandom), 0, 0);
    wr_ctrl(32'h5);
    rd_stat("stat_flush");
    wb_xfer(0, 2'd3, 32'h0, r);
    chk("ctrl_rd", r, 32'h4);
    wb_xfer(1, 2'd0, 32'hFFFF_FFFF, r);
    rd_stat("stat_wr_ignored");

    // Reset mid-frame with 3 bytes queued
    for (int i = 0; i < 3; i++) ps2_send(8'($urandom), 0, 0);
    rd_stat("stat_pre_rst");
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    PS2_Data = 1'b0;
    cyc(2);
    PS2_clk = 1'b0;
    cyc(1);
    @(negedge clk); rst = 1;
    cyc(2);
    PS2_clk = 1'b1; PS2_Data = 1'b1;
    @(negedge clk); rst = 0;
    model_reset();
    #1;
    chk("mrst_ready", 32'(ps2_ready), 32'd0);
    chk("mrst_key", 32'(key), 32'hAA);
    chk("mrst_key_d", key_d, 32'h0);
    chk("mrst_dat", dat_o, 32'h0);
    chk("mrst_ack", 32'(ack_o), 32'd0);
    rd_stat("stat_post_rst");
    b = 8'($urandom);
    ps2_send(b, 0, 0);
    chk_head("post_rst");
    rd_data("rd_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
